// File: rtl/ram_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// ram_arb_pkg
// Shared definitions for the RAM arbiter between the cdp1802 core and the
// host loader/debug port: default bus widths and the arbiter state type.
// ----------------------------------------------------------------------------
package ram_arb_pkg;

    // Default address and data widths of the shared RAM.
    localparam int RAM_ARB_AW = 16;
    localparam int RAM_ARB_DW = 8;

    // Arbiter states. The encodings are fixed because the top mirrors them
    // into plain logic [1:0] constants for the state register.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND   = 2'd1,
        RDWAIT = 2'd2,
        HOLD   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// ----------------------------------------------------------------------------
// ram_arbiter_if
// Host loader/debug port bus into the RAM arbiter.
//   host_valid  master->slave  request valid
//   host_ready  slave->master  request accepted when valid & ready
//   host_we     master->slave  1 = write, 0 = read
//   host_a      master->slave  address
//   host_d      master->slave  write data
//   host_rvalid slave->master  read data valid, one-cycle pulse
//   host_rdata  slave->master  read data, qualified by host_rvalid
// Modports: master (host bridge side), slave (arbiter side).
// ----------------------------------------------------------------------------
interface ram_arbiter_if
    import ram_arb_pkg::*;
#(
    parameter int AW = RAM_ARB_AW,
    parameter int DW = RAM_ARB_DW
) ();

    logic          host_valid;
    logic          host_ready;
    logic          host_we;
    logic [AW-1:0] host_a;
    logic [DW-1:0] host_d;
    logic          host_rvalid;
    logic [DW-1:0] host_rdata;

    modport master (
        output host_valid, host_we, host_a, host_d,
        input  host_ready, host_rvalid, host_rdata
    );

    modport slave (
        input  host_valid, host_we, host_a, host_d,
        output host_ready, host_rvalid, host_rdata
    );

endinterface

// File: rtl/ram_arbiter.sv
// ----------------------------------------------------------------------------
// ram_arbiter
// Shares one single-port synchronous RAM between the cdp1802 core and the
// host loader/debug port. The CPU has priority and sees the RAM directly;
// a host request is latched and issued on the first idle CPU cycle. After
// STARVE_LIMIT consecutive denied cycles the arbiter raises cpu_hold for one
// cycle and takes that slot for the host (STARVE_LIMIT = 0 disables this).
//
// Ports
//   clock, resetq            system clock, asynchronous active-low reset
//   cpu_rd/cpu_wr/cpu_a/cpu_d CPU access request (write wins if both set)
//   cpu_q                    read data to CPU (= ram_q)
//   cpu_hold                 registered; CPU stalls and repeats its access
//   host (ram_arbiter_if.slave) host request / read-return bus
//   ram_re/ram_we/ram_a/ram_d RAM strobes, address, write data
//   ram_q                    RAM read data, valid the cycle after ram_re
//
// Optional feature: macro RAM_ARB_STATS_EN adds parameter SW and outputs
//   stat_host_ops    issued host accesses, wraps modulo 2^SW
//   stat_hold_cycles cycles spent in the forced-slot state, wraps modulo 2^SW
// ----------------------------------------------------------------------------
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW           = RAM_ARB_AW,
    parameter int DW           = RAM_ARB_DW,
    parameter int STARVE_LIMIT = 15
`ifdef RAM_ARB_STATS_EN
    ,
    parameter int SW           = 16
`endif
) (
    input  logic          clock,
    input  logic          resetq,
    input  logic          cpu_rd,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_a,
    input  logic [DW-1:0] cpu_d,
    output logic [DW-1:0] cpu_q,
    output logic          cpu_hold,
    ram_arbiter_if.slave  host,
    output logic          ram_re,
    output logic          ram_we,
    output logic [AW-1:0] ram_a,
    output logic [DW-1:0] ram_d,
    input  logic [DW-1:0] ram_q
`ifdef RAM_ARB_STATS_EN
    ,
    output logic [SW-1:0] stat_host_ops,
    output logic [SW-1:0] stat_hold_cycles
`endif
);

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_PEND   = PEND;
    localparam logic [1:0] S_RDWAIT = RDWAIT;
    localparam logic [1:0] S_HOLD   = HOLD;

    // Wait counter only has to reach STARVE_LIMIT; keep at least one bit.
    localparam int            CW       = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CW-1:0] WAIT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] LIMIT_W  = CW'(STARVE_LIMIT);
    localparam bit            FORCE_EN = (STARVE_LIMIT > 0);

    logic [1:0]    state_r;
    logic [1:0]    state_s;
    logic [CW-1:0] wait_r;
    logic [CW-1:0] wait_s;
    logic          req_we_r;
    logic [AW-1:0] req_a_r;
    logic [DW-1:0] req_d_r;
    logic          hold_r;
    logic          rvalid_r;
    logic          cpu_busy_s;
    logic          accept_s;
    logic          host_slot_s;

    assign cpu_busy_s = cpu_rd | cpu_wr;
    // Ready is held low while reset is asserted even though the state is IDLE.
    assign host.host_ready  = (state_r == S_IDLE) & resetq;
    assign accept_s         = host.host_valid & (state_r == S_IDLE);
    assign host.host_rvalid = rvalid_r;
    assign host.host_rdata  = ram_q;
    assign cpu_q            = ram_q;
    assign cpu_hold         = hold_r;

    // Next-state, starvation counter and host-slot decision.
    always_comb begin
        state_s     = state_r;
        wait_s      = wait_r;
        host_slot_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    state_s = S_PEND;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_PEND: begin
                if (!cpu_busy_s) begin
                    host_slot_s = 1'b1;
                    wait_s      = {CW{1'b0}};
                    state_s     = req_we_r ? S_IDLE : S_RDWAIT;
                end else begin
                    // CPU wins this cycle; count the denial, saturating.
                    if (wait_r == WAIT_MAX) begin
                        wait_s = wait_r;
                    end else begin
                        wait_s = wait_r + CW'(1);
                    end
                    if (FORCE_EN && (wait_s >= LIMIT_W)) begin
                        state_s = S_HOLD;
                    end else begin
                        state_s = S_PEND;
                    end
                end
            end
            S_HOLD: begin
                // Forced slot: CPU is stalled by cpu_hold, host takes the RAM.
                host_slot_s = 1'b1;
                wait_s      = {CW{1'b0}};
                state_s     = req_we_r ? S_IDLE : S_RDWAIT;
            end
            S_RDWAIT: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
                wait_s  = {CW{1'b0}};
            end
        endcase
    end

    // RAM port mux: latched host request in a host slot, CPU otherwise.
    always_comb begin
        if (host_slot_s) begin
            ram_re = ~req_we_r;
            ram_we = req_we_r;
            ram_a  = req_a_r;
            ram_d  = req_d_r;
        end else begin
            ram_re = cpu_rd & ~cpu_wr;
            ram_we = cpu_wr;
            ram_a  = cpu_a;
            ram_d  = cpu_d;
        end
    end

    // State, counter and registered status outputs.
    always_ff @(posedge clock or negedge resetq) begin
        if (!resetq) begin
            state_r  <= S_IDLE;
            wait_r   <= {CW{1'b0}};
            hold_r   <= 1'b0;
            rvalid_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            wait_r   <= wait_s;
            hold_r   <= (state_s == S_HOLD);
            rvalid_r <= (state_s == S_RDWAIT);
        end
    end

    // Host request latch, loaded on acceptance; cleared on reset so no stale
    // request survives.
    always_ff @(posedge clock or negedge resetq) begin
        if (!resetq) begin
            req_we_r <= 1'b0;
            req_a_r  <= {AW{1'b0}};
            req_d_r  <= {DW{1'b0}};
        end else if (accept_s) begin
            req_we_r <= host.host_we;
            req_a_r  <= host.host_a;
            req_d_r  <= host.host_d;
        end else begin
            req_we_r <= req_we_r;
            req_a_r  <= req_a_r;
            req_d_r  <= req_d_r;
        end
    end

`ifdef RAM_ARB_STATS_EN
    logic [SW-1:0] stat_ops_r;
    logic [SW-1:0] stat_hold_r;

    assign stat_host_ops    = stat_ops_r;
    assign stat_hold_cycles = stat_hold_r;

    // Wrapping statistics counters.
    always_ff @(posedge clock or negedge resetq) begin
        if (!resetq) begin
            stat_ops_r  <= {SW{1'b0}};
            stat_hold_r <= {SW{1'b0}};
        end else begin
            stat_ops_r  <= stat_ops_r + (host_slot_s ? SW'(1) : SW'(0));
            stat_hold_r <= stat_hold_r + ((state_r == S_HOLD) ? SW'(1) : SW'(0));
        end
    end
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ram_arbiter
// Directed and randomized bench for ram_arbiter. Two instances: u_dut_a with
// STARVE_LIMIT=15 and u_dut_b with STARVE_LIMIT=0, sharing the CPU bus, each
// with its own host interface and RAM model. Random phase checks read data
// against a shadow memory kept by the bench.
// ----------------------------------------------------------------------------
module tb_ram_arbiter;
    localparam int LIM = 15;

    logic        clock = 1'b0;
    logic        resetq = 1'b0;
    logic        cpu_rd, cpu_wr;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_d;
    logic [7:0]  cpu_q_a, cpu_q_b;
    logic        hold_a, hold_b;
    logic        ram_re_a, ram_we_a, ram_re_b, ram_we_b;
    logic [15:0] ram_a_a, ram_a_b;
    logic [7:0]  ram_d_a, ram_d_b, ram_q_a, ram_q_b;
    logic [7:0]  mem_a [0:65535];
    logic [7:0]  mem_b [0:65535];
`ifdef RAM_ARB_STATS_EN
    logic [15:0] sho_a, shc_a, sho_b, shc_b;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    ram_arbiter_if #(.AW(16), .DW(8)) hif_a ();
    ram_arbiter_if #(.AW(16), .DW(8)) hif_b ();

    ram_arbiter #(.AW(16), .DW(8), .STARVE_LIMIT(LIM)
`ifdef RAM_ARB_STATS_EN
        , .SW(16)
`endif
    ) u_dut_a (
        .clock(clock), .resetq(resetq),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_a(cpu_a), .cpu_d(cpu_d),
        .cpu_q(cpu_q_a), .cpu_hold(hold_a), .host(hif_a),
        .ram_re(ram_re_a), .ram_we(ram_we_a), .ram_a(ram_a_a), .ram_d(ram_d_a),
        .ram_q(ram_q_a)
`ifdef RAM_ARB_STATS_EN
        , .stat_host_ops(sho_a), .stat_hold_cycles(shc_a)
`endif
    );

    ram_arbiter #(.AW(16), .DW(8), .STARVE_LIMIT(0)
`ifdef RAM_ARB_STATS_EN
        , .SW(16)
`endif
    ) u_dut_b (
        .clock(clock), .resetq(resetq),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_a(cpu_a), .cpu_d(cpu_d),
        .cpu_q(cpu_q_b), .cpu_hold(hold_b), .host(hif_b),
        .ram_re(ram_re_b), .ram_we(ram_we_b), .ram_a(ram_a_b), .ram_d(ram_d_b),
        .ram_q(ram_q_b)
`ifdef RAM_ARB_STATS_EN
        , .stat_host_ops(sho_b), .stat_hold_cycles(shc_b)
`endif
    );

    // Clock generation.
    always #5 clock = ~clock;

    // Single-port synchronous RAM models.
    always @(posedge clock) begin
        if (ram_we_a) mem_a[ram_a_a] <= ram_d_a;
        if (ram_re_a) ram_q_a <= mem_a[ram_a_a];
        if (ram_we_b) mem_b[ram_a_b] <= ram_d_b;
        if (ram_re_b) ram_q_b <= mem_b[ram_a_b];
    end

    // Safety net against a stuck simulation.
    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic smp();
        @(negedge clock);
    endtask

    // Random-phase model state.
    logic [7:0]  exp_mem [0:511];
    bit          known   [0:511];
    int          c_op, h_st, h_wait, holds, r;
    logic [15:0] c_addr, h_addr, acc_addr;
    logic [7:0]  c_dat, h_dat, c_rd_exp, h_exp;
    logic        h_we, c_rd_chk, c_rd_known, h_known, held;

    initial begin
        cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_a = 16'h0000; cpu_d = 8'h00;
        hif_a.host_valid = 1'b0; hif_a.host_we = 1'b0; hif_a.host_a = 16'h0000; hif_a.host_d = 8'h00;
        hif_b.host_valid = 1'b0; hif_b.host_we = 1'b0; hif_b.host_a = 16'h0000; hif_b.host_d = 8'h00;

        // Reset state.
        resetq = 1'b0;
        repeat (3) @(posedge clock);
        smp();
        chk("rst_ready", hif_a.host_ready, 1'b0);
        chk("rst_hold", hold_a, 1'b0);
        chk("rst_rvalid", hif_a.host_rvalid, 1'b0);
        @(posedge clock); #1; resetq = 1'b1;
        smp();
        chk("post_rst_ready", hif_a.host_ready, 1'b1);

        // 1: host write then read, CPU idle.
        cyc(); hif_a.host_valid = 1'b1; hif_a.host_we = 1'b1; hif_a.host_a = 16'h0100; hif_a.host_d = 8'hA5;
        smp(); chk("t1_idle_no_we", ram_we_a, 1'b0);
        cyc(); hif_a.host_valid = 1'b0;
        smp(); chk("t1_wr_we", ram_we_a, 1'b1); chk("t1_wr_addr", ram_a_a, 16'h0100);
        chk("t1_wr_data", ram_d_a, 8'hA5); chk("t1_busy_ready", hif_a.host_ready, 1'b0);
        cyc(); hif_a.host_valid = 1'b1; hif_a.host_we = 1'b0; hif_a.host_a = 16'h0100;
        smp(); chk("t1_rd_ready", hif_a.host_ready, 1'b1);
        cyc(); hif_a.host_valid = 1'b0;
        smp(); chk("t1_rd_re", ram_re_a, 1'b1); chk("t1_rd_addr", ram_a_a, 16'h0100);
        chk("t1_rvalid_early", hif_a.host_rvalid, 1'b0);
        cyc(); smp(); chk("t1_rvalid", hif_a.host_rvalid, 1'b1); chk("t1_rdata", hif_a.host_rdata, 8'hA5);
        cyc(); smp(); chk("t1_rvalid_pulse", hif_a.host_rvalid, 1'b0);

        // 4: simultaneous CPU read and write, the write wins.
        cyc(); cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_a = 16'h0010; cpu_d = 8'h3C;
        smp(); chk("t4_we", ram_we_a, 1'b1); chk("t4_re", ram_re_a, 1'b0); chk("t4_addr", ram_a_a, 16'h0010);
        cyc(); cpu_wr = 1'b0;
        smp(); chk("t4_rd_re", ram_re_a, 1'b1);
        cyc(); cpu_rd = 1'b0;
        smp(); chk("t4_cpu_q_a", cpu_q_a, 8'h3C); chk("t4_cpu_q_b", cpu_q_b, 8'h3C);

        // 2: CPU busy, host read starved until the forced slot.
        cyc(); cpu_rd = 1'b1; cpu_a = 16'h0010;
        hif_a.host_valid = 1'b1; hif_a.host_we = 1'b0; hif_a.host_a = 16'h0100;
        smp(); chk("t2_accept_ready", hif_a.host_ready, 1'b1);
        holds = 0;
        for (int k = 1; k <= 40; k++) begin
            cyc(); if (k == 1) hif_a.host_valid = 1'b0;
            smp();
            chk($sformatf("t2_hold_k%0d", k), hold_a, (k == LIM + 1) ? 1'b1 : 1'b0);
            if (k <= LIM) begin
                chk($sformatf("t2_cpu_wins_k%0d", k), ram_a_a, 16'h0010);
            end else if (k == LIM + 1) begin
                chk("t2_hold_addr", ram_a_a, 16'h0100);
                chk("t2_hold_re", ram_re_a, 1'b1);
            end else if (k == LIM + 2) begin
                chk("t2_rvalid", hif_a.host_rvalid, 1'b1);
                chk("t2_rdata", hif_a.host_rdata, 8'hA5);
            end else begin
                chk($sformatf("t2_no_rvalid_k%0d", k), hif_a.host_rvalid, 1'b0);
            end
            holds += int'(hold_a);
        end
        chk("t2_hold_count", holds, 1);
        cyc(); cpu_rd = 1'b0;

        // 3: no forced slot when the limit is zero.
        hif_b.host_valid = 1'b1; hif_b.host_we = 1'b0; hif_b.host_a = 16'h0010;
        cpu_rd = 1'b1; cpu_a = 16'h0000;
        smp(); chk("t3_ready", hif_b.host_ready, 1'b1);
        holds = 0;
        for (int k = 1; k <= 100; k++) begin
            cyc(); if (k == 1) hif_b.host_valid = 1'b0;
            smp();
            holds += int'(hold_b);
            if (k == 100) chk("t3_cpu_still_wins", ram_a_b, 16'h0000);
        end
        chk("t3_no_hold", holds, 0);
        cyc(); cpu_rd = 1'b0;
        smp(); chk("t3_first_idle_re", ram_re_b, 1'b1); chk("t3_first_idle_addr", ram_a_b, 16'h0010);
        cyc(); smp(); chk("t3_rvalid", hif_b.host_rvalid, 1'b1); chk("t3_rdata", hif_b.host_rdata, 8'h3C);

        // 5: reset asserted during the read-return cycle.
        cyc(); hif_a.host_valid = 1'b1; hif_a.host_we = 1'b0; hif_a.host_a = 16'h0100;
        smp();
        cyc(); hif_a.host_valid = 1'b0;
        smp();
        cyc(); smp(); chk("t5_in_rdwait", hif_a.host_rvalid, 1'b1);
        resetq = 1'b0; #1;
        chk("t5_rvalid_async", hif_a.host_rvalid, 1'b0);
        chk("t5_hold_async", hold_a, 1'b0);
        chk("t5_ready_async", hif_a.host_ready, 1'b0);
        repeat (2) @(posedge clock);
        #1; resetq = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) cyc();
            smp();
            chk($sformatf("t5_no_stale_rvalid_%0d", k), hif_a.host_rvalid, 1'b0);
            chk($sformatf("t5_ready_back_%0d", k), hif_a.host_ready, 1'b1);
        end

`ifdef RAM_ARB_STATS_EN
        // 6: statistics after two plain host ops and one forced slot.
        chk("t6_ops_rst", sho_a, 16'd0);
        chk("t6_hold_rst", shc_a, 16'd0);
        for (int i = 0; i < 2; i++) begin
            cyc(); hif_a.host_valid = 1'b1; hif_a.host_we = 1'b1;
            hif_a.host_a = 16'h0101 + 16'(i); hif_a.host_d = 8'h11 + 8'(i);
            smp();
            cyc(); hif_a.host_valid = 1'b0;
            smp();
        end
        cyc(); cpu_rd = 1'b1; cpu_a = 16'h0000;
        hif_a.host_valid = 1'b1; hif_a.host_we = 1'b0; hif_a.host_a = 16'h0101;
        smp();
        for (int k = 1; k <= LIM + 3; k++) begin
            cyc(); if (k == 1) hif_a.host_valid = 1'b0;
            smp();
        end
        cyc(); cpu_rd = 1'b0;
        smp();
        chk("t6_host_ops", sho_a, 16'd3);
        chk("t6_hold_cycles", shc_a, 16'd1);
`endif

        // Random phase: CPU in 0x0000-0x000F, host in 0x0100-0x010F.
        for (int i = 0; i < 512; i++) known[i] = 1'b0;
        c_op = 0; h_st = 0; h_wait = 0; held = 1'b0; c_rd_chk = 1'b0;
        c_addr = 16'h0000; c_dat = 8'h00; h_addr = 16'h0100; h_dat = 8'h00; h_we = 1'b0;
        acc_addr = 16'h0100;
        for (int n = 0; n < 800; n++) begin
            cyc();
            if (!held) begin
                r = int'($urandom_range(0, 3));
                c_op   = (r < 2) ? 0 : ((r == 2) ? 1 : 2);
                c_addr = {12'h000, 4'($urandom_range(0, 15))};
                c_dat  = 8'($urandom);
            end
            cpu_rd = (c_op == 1); cpu_wr = (c_op == 2); cpu_a = c_addr; cpu_d = c_dat;
            if (h_st == 0 && $urandom_range(0, 2) == 0) begin
                h_we   = 1'($urandom_range(0, 1));
                h_addr = {12'h010, 4'($urandom_range(0, 15))};
                h_dat  = 8'($urandom);
                h_st   = 1;
            end
            hif_a.host_valid = (h_st == 1); hif_a.host_we = h_we;
            hif_a.host_a = h_addr; hif_a.host_d = h_dat;
            smp();
            if (c_rd_chk && c_rd_known) chk("rnd_cpu_q", cpu_q_a, c_rd_exp);
            c_rd_chk = 1'b0;
            held = hold_a;
            if (hold_a && c_op != 0) chk("rnd_hold_host_addr", ram_a_a, acc_addr);
            if (!hold_a) begin
                if (c_op == 2) begin
                    exp_mem[c_addr[8:0]] = c_dat; known[c_addr[8:0]] = 1'b1;
                end else if (c_op == 1) begin
                    c_rd_chk = 1'b1; c_rd_exp = exp_mem[c_addr[8:0]]; c_rd_known = known[c_addr[8:0]];
                end
            end
            if (h_st == 2) begin
                if (hif_a.host_rvalid) begin
                    if (h_known) chk("rnd_host_rdata", hif_a.host_rdata, h_exp);
                    h_st = 0;
                end else begin
                    h_wait++;
                    if (h_wait > 64) begin
                        chk("rnd_rvalid_timeout", hif_a.host_rvalid, 1'b1);
                        h_st = 0;
                    end
                end
            end else begin
                chk("rnd_spurious_rvalid", hif_a.host_rvalid, 1'b0);
            end
            if (h_st == 1 && hif_a.host_ready) begin
                acc_addr = h_addr;
                if (h_we) begin
                    exp_mem[h_addr[8:0]] = h_dat; known[h_addr[8:0]] = 1'b1; h_st = 0;
                end else begin
                    h_exp = exp_mem[h_addr[8:0]]; h_known = known[h_addr[8:0]];
                    h_st = 2; h_wait = 0;
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
